datapath_param: RTL and testbench
=================================

// Module: datapath_param
// PURPOSE
//  Parametrised successor of the 16-bit processor datapath. Holds the register file, PC, LR, IR, ALU
//  result register and flag register, plus a full-length scan chain for test. Width and register
//  count are generic; an optional hardwired-zero R0 is added. Sits between the control FSM (drives all
//  selects/enables) and the memory interface (Addr/DataIn/DataOut).
// PARAMETERS
//  WIDTH     16  datapath width in bits, >=8
//  NREGS     8   register-file depth, power of 2, >=2
//  RADDR     $clog2(NREGS)  register address width (derived, do not override)
//  PC_RESET  0   PC value loaded on Reset
//  R0_ZERO   0   1: R0 reads as 0, functional writes to R0 ignored
// PORTS
//  Clock     in   1      single clock, all state updates on rising edge
//  Reset     in   1      synchronous, active-high
//  Test      in   1      1: scan-shift mode
//  SDI       in   1      scan data in
//  SDO       out  1      scan data out
//  DataIn    in   WIDTH  memory read data
//  DataOut   out  WIDTH  store data (= Rd2)
//  Addr      out  WIDTH  MemEn ? Pc : AluRegOut
//  MemEn     in   1      address source select
//  Ir        out  WIDTH  instruction register
//  IrWe      in   1      load Ir from DataIn
//  Rs1,Rs2   in   RADDR  read addresses
//  Rw        in   RADDR  write address
//  RegWe     in   1      register-file write enable
//  WdSel     in   2      write data: 00 AluRegOut, 01 DataIn, 10 PcPlus1, 11 Lr
//  ImmSel    in   1      0: sext(Ir[7:0]), 1: sext(Ir[4:0])
//  Op1Sel    in   1      Operand1: 0 Rd1, 1 Pc
//  Op2Sel    in   2      Operand2: 00 Rd2, 01 Imm, 10 const 1, 11 Lr
//  AluOp     in   3      000 ADD 001 ADC 010 SUB 011 SBC 100 AND 101 OR 110 XOR 111 PASSB
//  AluWe     in   1      capture ALU result into AluRegOut
//  FlagsWe   in   1      capture flags
//  PcWe      in   1      PC load enable
//  PcSel     in   2      next PC: 00 PcPlus1, 01 AluRegOut, 10 Lr, 11 Rd1
//  LrWe      in   1      Lr <= PcPlus1
//  Flags     out  4      {N,Z,C,V} registered
// BEHAVIOUR
//  - Reset (priority over Test and all enables): regs, Ir, Lr, AluRegOut, Flags <= 0; Pc <= PC_RESET.
//    Hence SDO=0, Flags=0, Addr=PC_RESET if MemEn, DataOut=0 after reset.
//  - Reads combinational; Rd1=R[Rs1], Rd2=R[Rs2]; with R0_ZERO=1 address 0 reads 0.
//  - Writes 1-cycle: value visible on reads the cycle after the edge. Same-cycle read/write of one
//    register returns the old value (no bypass).
//  - PcPlus1 = Pc+1 mod 2^WIDTH (wraps max->0). Independent enables: Pc, Lr, Ir, regs, AluRegOut,
//    Flags may all update on one edge, each from pre-edge values.
//  - ALU: ADD A+B; ADC A+B+C; SUB A-B (A+~B+1); SBC A+~B+C (C=1 means no borrow); C = carry out of
//    bit WIDTH-1; V = signed overflow for add/sub, 0 for logic/PASSB; logic/PASSB leave C unchanged.
//    N = result MSB, Z = result==0. C used by ADC/SBC is registered Flags C.
//  - Test=1: functional updates suppressed; every edge shifts chain one bit. Chain order SDI ->
//    R0[0..W-1] -> R1 ... R(NREGS-1) -> Pc -> Lr -> Ir -> AluRegOut -> Flags[0..3] -> SDO
//    (SDO = Flags[3]). Length L = (NREGS+4)*WIDTH+4. R0 storage is in chain even with R0_ZERO=1.
//  - Test deasserted mid-shift: next edge functional, chain contents as shifted so far.
// TESTING
//  Reset with PC_RESET=16'h0100, MemEn=1 -> Addr=0100, Flags=0, all regs 0 via scan-out.
//  Write R3<=DataIn 1234, next cycle Rs1=3 -> Rd1=1234; same-cycle read returns 0000.
//  ADD 7FFF+0001, FlagsWe -> AluRegOut=8000, Flags N=1 Z=0 C=0 V=1; SUB 5-5 -> Z=1 C=1.
//  PcSel=00 from FFFF, PcWe -> Pc=0000; LrWe same edge -> Lr=0000 (PcPlus1).
//  R0_ZERO=1: write R0<=ABCD -> Rd1(Rs1=0)=0000.
//  Test=1, shift L bits pattern A5.. -> SDO reproduces pattern after L cycles; Reset mid-shift -> 0s.

Source files
------------

// File: rtl/datapath_param.sv
// Parametrised processor datapath: register file, PC, LR, IR, ALU result and flag registers,
// with a full-length scan chain threaded through every state bit.
module datapath_param #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      NREGS    = 8,
    parameter int unsigned      RADDR    = $clog2(NREGS),
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter bit               R0_ZERO  = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Test,
    input  logic             SDI,
    output logic             SDO,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataOut,
    output logic [WIDTH-1:0] Addr,
    input  logic             MemEn,
    output logic [WIDTH-1:0] Ir,
    input  logic             IrWe,
    input  logic [RADDR-1:0] Rs1,
    input  logic [RADDR-1:0] Rs2,
    input  logic [RADDR-1:0] Rw,
    input  logic             RegWe,
    input  logic [1:0]       WdSel,
    input  logic             ImmSel,
    input  logic             Op1Sel,
    input  logic [1:0]       Op2Sel,
    input  logic [2:0]       AluOp,
    input  logic             AluWe,
    input  logic             FlagsWe,
    input  logic             PcWe,
    input  logic [1:0]       PcSel,
    input  logic             LrWe,
    output logic [3:0]       Flags
);

    localparam int unsigned ChainLen = (NREGS + 4) * WIDTH + 4;

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] pc_q, lr_q, ir_q, alu_q;
    logic [3:0]       flags_q;

    logic [WIDTH-1:0] rd1, rd2, pc_plus1, imm, op1, op2, wd, pc_d;
    logic [WIDTH-1:0] b_eff, alu_res;
    logic [WIDTH:0]   sum;
    logic             cin, arith, ovf;
    logic [3:0]       flags_d;
    logic [ChainLen-1:0] chain, chain_next;

    always_comb begin
        rd1 = rf_q[Rs1];
        rd2 = rf_q[Rs2];
        if (R0_ZERO && Rs1 == '0) rd1 = '0;
        if (R0_ZERO && Rs2 == '0) rd2 = '0;
    end

    assign pc_plus1 = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign imm      = ImmSel ? WIDTH'($signed(ir_q[4:0])) : WIDTH'($signed(ir_q[7:0]));
    assign op1      = Op1Sel ? pc_q : rd1;

    always_comb begin
        case (Op2Sel)
            2'b00:   op2 = rd2;
            2'b01:   op2 = imm;
            2'b10:   op2 = {{(WIDTH-1){1'b0}}, 1'b1};
            default: op2 = lr_q;
        endcase
        case (WdSel)
            2'b00:   wd = alu_q;
            2'b01:   wd = DataIn;
            2'b10:   wd = pc_plus1;
            default: wd = lr_q;
        endcase
        case (PcSel)
            2'b00:   pc_d = pc_plus1;
            2'b01:   pc_d = alu_q;
            2'b10:   pc_d = lr_q;
            default: pc_d = rd1;
        endcase
    end

    // Subtraction is A + ~B + carry-in, so C=1 after SUB/SBC means "no borrow".
    always_comb begin
        b_eff = op2;
        cin   = 1'b0;
        arith = 1'b1;
        case (AluOp)
            3'b001: cin = flags_q[1];
            3'b010: begin
                b_eff = ~op2;
                cin   = 1'b1;
            end
            3'b011: begin
                b_eff = ~op2;
                cin   = flags_q[1];
            end
            3'b000:  ;
            default: arith = 1'b0;
        endcase
        sum = {1'b0, op1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        case (AluOp)
            3'b100:  alu_res = op1 & op2;
            3'b101:  alu_res = op1 | op2;
            3'b110:  alu_res = op1 ^ op2;
            3'b111:  alu_res = op2;
            default: alu_res = sum[WIDTH-1:0];
        endcase
        ovf     = (op1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
        flags_d = {alu_res[WIDTH-1], alu_res == '0, arith ? sum[WIDTH] : flags_q[1], arith & ovf};
    end

    // Chain bit 0 is R0[0] (nearest SDI); the top bit is Flags[3] (drives SDO).
    always_comb begin
        chain = '0;
        for (int i = 0; i < NREGS; i++) chain[i*WIDTH +: WIDTH] = rf_q[i];
        chain[NREGS*WIDTH +: WIDTH]     = pc_q;
        chain[(NREGS+1)*WIDTH +: WIDTH] = lr_q;
        chain[(NREGS+2)*WIDTH +: WIDTH] = ir_q;
        chain[(NREGS+3)*WIDTH +: WIDTH] = alu_q;
        chain[ChainLen-1 -: 4]          = flags_q;
        chain_next = {chain[ChainLen-2:0], SDI};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            pc_q    <= PC_RESET;
            lr_q    <= '0;
            ir_q    <= '0;
            alu_q   <= '0;
            flags_q <= '0;
        end else if (Test) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= chain_next[i*WIDTH +: WIDTH];
            pc_q    <= chain_next[NREGS*WIDTH +: WIDTH];
            lr_q    <= chain_next[(NREGS+1)*WIDTH +: WIDTH];
            ir_q    <= chain_next[(NREGS+2)*WIDTH +: WIDTH];
            alu_q   <= chain_next[(NREGS+3)*WIDTH +: WIDTH];
            flags_q <= chain_next[ChainLen-1 -: 4];
        end else begin
            if (RegWe && !(R0_ZERO && Rw == '0)) rf_q[Rw] <= wd;
            if (PcWe)    pc_q    <= pc_d;
            if (LrWe)    lr_q    <= pc_plus1;
            if (IrWe)    ir_q    <= DataIn;
            if (AluWe)   alu_q   <= alu_res;
            if (FlagsWe) flags_q <= flags_d;
        end
    end

    assign SDO     = chain[ChainLen-1];
    assign DataOut = rd2;
    assign Addr    = MemEn ? pc_q : alu_q;
    assign Ir      = ir_q;
    assign Flags   = flags_q;

endmodule

// File: tb/tb_datapath_param.sv
// Directed self-checking bench for datapath_param (16-bit, 8 registers, PC reset 0100, R0 zero).
module tb_datapath_param;

    localparam int W = 16;
    localparam int N = 8;
    localparam int L = (N + 4) * W + 4;

    logic        Clock = 1'b0;
    logic        Reset, Test, SDI, SDO, MemEn, IrWe, RegWe, ImmSel, Op1Sel;
    logic        AluWe, FlagsWe, PcWe, LrWe;
    logic [15:0] DataIn, DataOut, Addr, Ir;
    logic [2:0]  Rs1, Rs2, Rw, AluOp;
    logic [1:0]  WdSel, Op2Sel, PcSel;
    logic [3:0]  Flags;

    int passed = 0;
    int total  = 0;

    logic [L-1:0] vin, vout, exp_chain;
    logic [7:0]   a5;

    datapath_param #(
        .WIDTH(16), .NREGS(8), .PC_RESET(16'h0100), .R0_ZERO(1'b1)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Test(Test), .SDI(SDI), .SDO(SDO),
        .DataIn(DataIn), .DataOut(DataOut), .Addr(Addr), .MemEn(MemEn), .Ir(Ir),
        .IrWe(IrWe), .Rs1(Rs1), .Rs2(Rs2), .Rw(Rw), .RegWe(RegWe), .WdSel(WdSel),
        .ImmSel(ImmSel), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel), .AluOp(AluOp), .AluWe(AluWe),
        .FlagsWe(FlagsWe), .PcWe(PcWe), .PcSel(PcSel), .LrWe(LrWe), .Flags(Flags)
    );

    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] r, input logic [1:0] sel, input logic [15:0] d);
        Rw = r; WdSel = sel; DataIn = d; RegWe = 1'b1;
        tick;
        RegWe = 1'b0;
    endtask

    task automatic alu(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [1:0] o2, input logic fl);
        AluOp = op; Rs1 = a; Rs2 = b; Op2Sel = o2; AluWe = 1'b1; FlagsWe = fl;
        tick;
        AluWe = 1'b0; FlagsWe = 1'b0;
        #1;
    endtask

    task automatic scan(input logic [L-1:0] din, output logic [L-1:0] dout);
        for (int k = 0; k < L; k++) begin
            SDI = din[L-1-k];
            dout[L-1-k] = SDO;
            tick;
        end
    endtask

    function automatic logic [L-1:0] mk_chain(input logic [N*W-1:0] regs, input logic [15:0] pc,
                                              input logic [15:0] lr, input logic [15:0] ir,
                                              input logic [15:0] al, input logic [3:0] fl);
        return {fl, al, ir, lr, pc, regs};
    endfunction

    initial begin
        Test = 0; SDI = 0; MemEn = 1; IrWe = 0; ImmSel = 0; Op1Sel = 0; Op2Sel = 0;
        AluOp = 0; AluWe = 0; FlagsWe = 0; PcSel = 0; LrWe = 0; Rs1 = 0; Rs2 = 1;
        // Reset must win over enables held active.
        Reset = 1; RegWe = 1; Rw = 1; WdSel = 2'b01; DataIn = 16'hFFFF; PcWe = 1;
        tick; tick;
        Reset = 0; RegWe = 0; PcWe = 0;
        #1;
        check("reset_addr", Addr, 16'h0100);
        check("reset_flags", Flags, 4'h0);
        check("reset_r1", DataOut, 16'h0000);
        check("reset_sdo", SDO, 1'b0);
        check("reset_ir", Ir, 16'h0000);

        // Same-cycle read of a register being written returns the old value.
        Rw = 3; WdSel = 2'b01; DataIn = 16'h1234; RegWe = 1; Rs2 = 3; LrWe = 1;
        #1;
        check("same_cycle_read", DataOut, 16'h0000);
        tick;
        RegWe = 0; LrWe = 0;
        #1;
        check("r3_written", DataOut, 16'h1234);
        wr(7, 2'b11, 16'h0000);
        Rs2 = 7; #1;
        check("lr_pcplus1", DataOut, 16'h0101);
        wr(6, 2'b10, 16'h0000);
        Rs2 = 6; #1;
        check("wd_pcplus1", DataOut, 16'h0101);
        wr(1, 2'b01, 16'h7FFF);
        wr(2, 2'b01, 16'h0001);
        wr(4, 2'b01, 16'h0005);
        wr(5, 2'b01, 16'hFFFF);

        MemEn = 0;
        alu(3'b000, 1, 2, 2'b00, 1'b1);
        check("add_res", Addr, 16'h8000);
        check("add_flags", Flags, 4'b1001);
        alu(3'b010, 4, 4, 2'b00, 1'b1);
        check("sub_res", Addr, 16'h0000);
        check("sub_flags", Flags, 4'b0110);
        alu(3'b001, 1, 2, 2'b00, 1'b1);
        check("adc_res", Addr, 16'h8001);
        check("adc_flags", Flags, 4'b1001);
        alu(3'b011, 4, 2, 2'b00, 1'b1);
        check("sbc_res", Addr, 16'h0003);
        check("sbc_flags", Flags, 4'b0010);
        alu(3'b100, 1, 3, 2'b00, 1'b1);
        check("and_res", Addr, 16'h1234);
        check("and_flags", Flags, 4'b0010);

        IrWe = 1; DataIn = 16'h00EF;
        tick;
        IrWe = 0; #1;
        check("ir_load", Ir, 16'h00EF);
        ImmSel = 0;
        alu(3'b111, 0, 0, 2'b01, 1'b1);
        check("imm8", Addr, 16'hFFEF);
        check("imm8_flags", Flags, 4'b1010);
        ImmSel = 1;
        alu(3'b111, 0, 0, 2'b01, 1'b1);
        check("imm5", Addr, 16'h000F);
        Op1Sel = 1;
        alu(3'b000, 0, 0, 2'b10, 1'b1);
        Op1Sel = 0;
        check("pc_plus_const", Addr, 16'h0101);
        check("pc_plus_flags", Flags, 4'b0000);
        alu(3'b111, 0, 5, 2'b00, 1'b0);
        check("passb_noflags", Flags, 4'b0000);

        // PC wrap with LR captured on the same edge.
        MemEn = 1; PcWe = 1; PcSel = 2'b01;
        tick; #1;
        check("pc_from_alu", Addr, 16'hFFFF);
        PcSel = 2'b00; LrWe = 1;
        tick;
        PcWe = 0; LrWe = 0; #1;
        check("pc_wrap", Addr, 16'h0000);
        wr(6, 2'b11, 16'h0000);
        Rs2 = 6; #1;
        check("lr_wrap", DataOut, 16'h0000);
        wr(0, 2'b01, 16'hABCD);
        Rs2 = 0; #1;
        check("r0_zero_rd2", DataOut, 16'h0000);
        PcWe = 1; PcSel = 2'b11; Rs1 = 3;
        tick; #1;
        check("pc_from_rd1", Addr, 16'h1234);
        Rs1 = 0;
        tick;
        PcWe = 0; #1;
        check("r0_zero_rd1", Addr, 16'h0000);

        // Scan out the known state; functional enables held high must have no effect.
        a5 = 8'hA5;
        for (int i = 0; i < L; i++) vin[i] = a5[i%8];
        exp_chain = mk_chain({16'h0101, 16'h0000, 16'hFFFF, 16'h0005,
                              16'h1234, 16'h0001, 16'h7FFF, 16'h0000},
                             16'h0000, 16'h0000, 16'h00EF, 16'hFFFF, 4'h0);
        Test = 1; RegWe = 1; Rw = 7; WdSel = 2'b01; DataIn = 16'hDEAD;
        AluWe = 1; FlagsWe = 1; PcWe = 1; LrWe = 1; IrWe = 1;
        scan(vin, vout);
        check("scan_state", vout, exp_chain);
        scan(vin, vout);
        check("scan_pattern", vout, vin);
        Test = 0; RegWe = 0; AluWe = 0; FlagsWe = 0; PcWe = 0; LrWe = 0; IrWe = 0;
        Rs2 = 1; MemEn = 1;
        #1;
        check("scan_r1", DataOut, vin[2*W-1:W]);
        check("scan_pc", Addr, vin[N*W +: W]);
        check("scan_ir", Ir, vin[(N+2)*W +: W]);
        check("scan_flags", Flags, vin[L-1 -: 4]);
        Rs2 = 0; #1;
        check("scan_r0_masked", DataOut, 16'h0000);

        // Reset in the middle of a shift.
        Test = 1;
        for (int k = 0; k < 10; k++) begin
            SDI = 1'b1;
            tick;
        end
        Reset = 1;
        tick;
        Reset = 0; Test = 0; #1;
        check("midshift_sdo", SDO, 1'b0);
        check("midshift_flags", Flags, 4'h0);
        check("midshift_addr", Addr, 16'h0100);
        Test = 1;
        scan('0, vout);
        Test = 0;
        check("midshift_chain", vout, mk_chain('0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 4'h0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
